// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue
// Instruction queue between fetch and decode. Fetch results that hit in the
// icache are captured as {pc, instr, fault} and presented to decode in order
// through a valid/ready handshake. A flush discards everything in flight.
// Once an entry carrying an iTLB miss fault is accepted, further pushes are
// refused until flush or reset, so the faulting instruction is the last one
// decode sees before the redirect.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an incoming entry is forwarded combinationally to d_* while
//   the queue is empty. If decode takes it in the same cycle, it is never
//   written. When undefined, f_* has no combinational path to d_*.
module cpu_fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     f_valid,
    input  logic [ADDR_WIDTH-1:0]    f_pc,
    input  logic [INSTR_WIDTH-1:0]   f_instr,
    input  logic                     f_cache_hit,
    input  logic                     f_tlb_enable,
    input  logic                     f_tlb_hit,
    output logic                     f_ready,
    output logic                     d_valid,
    output logic [ADDR_WIDTH-1:0]    d_pc,
    output logic [INSTR_WIDTH-1:0]   d_instr,
    output logic                     d_tlb_fault,
    input  logic                     d_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH + 1;

    logic [EW-1:0] entry_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          fault_block_reg;

    logic          in_fault;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic          empty;
    logic          push;
    logic          pop;
    logic          write_en;
    logic          read_en;

    assign in_fault   = f_tlb_enable & ~f_tlb_hit;
    assign in_entry   = {f_pc, f_instr, in_fault};
    assign head_entry = entry_reg[rd_ptr_reg];
    assign empty      = (count_reg == '0);
    assign f_ready    = (count_reg < CW'(DEPTH)) & ~fault_block_reg;
    assign push       = f_valid & f_cache_hit & f_ready & ~flush;
    assign count      = count_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass   = empty & push;
    assign d_valid  = ~empty | bypass;
    assign pop      = d_valid & d_ready & ~flush;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign write_en = push & ~(bypass & d_ready);
    assign read_en  = pop & ~empty;

    // Head presentation: stored head first, then the forwarded entry, else zero.
    always_comb begin
        {d_pc, d_instr, d_tlb_fault} = '0;
        if (!empty) begin
            {d_pc, d_instr, d_tlb_fault} = head_entry;
        end else if (bypass) begin
            {d_pc, d_instr, d_tlb_fault} = in_entry;
        end
    end
`else
    assign d_valid  = ~empty;
    assign pop      = d_valid & d_ready & ~flush;
    assign write_en = push;
    assign read_en  = pop;

    // Head presentation: stored head when valid, otherwise all zero.
    always_comb begin
        {d_pc, d_instr, d_tlb_fault} = '0;
        if (!empty) begin
            {d_pc, d_instr, d_tlb_fault} = head_entry;
        end
    end
`endif

    // Entry storage: each slot captures the incoming entry when it is the write target.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (write_en && (wr_ptr_reg == PW'(gi))) begin
                entry_reg[gi] <= in_entry;
            end
        end
    end

    // Pointer, occupancy and fault-block bookkeeping; reset beats flush.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            fault_block_reg <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (read_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({write_en, read_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Includes a bypassed fault entry: the block must still engage.
            if (push && in_fault) begin
                fault_block_reg <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cpu_fetch_queue.md
Name: cpu_fetch_queue

Overview:
- Instruction queue between the fetch stage and decode.
- Captures each fetch result (pc, instruction word, TLB fault flag) when the icache hits, then presents entries in order to decode with a valid/ready handshake.
- Decouples icache-miss bubbles from decode stalls; backpressures fetch when full.
- Discards all in-flight instructions on flush (jump or exception redirect).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_WIDTH, 32, pc width (`VIRTUAL_ADDR_WIDTH)
- INSTR_WIDTH, 32, instruction width (`REG_WIDTH)

Ports:
- clock  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all entries; asserted by the redirect (jump/exception) logic
- f_valid  in  1  fetch presents a request this cycle
- f_pc  in  ADDR_WIDTH  pc of fetched instruction
- f_instr  in  INSTR_WIDTH  instruction word from icache
- f_cache_hit  in  1  icache hit; instruction word valid
- f_tlb_enable  in  1  translation enabled
- f_tlb_hit  in  1  iTLB hit
- f_ready  out  1  queue can accept; fetch must hold pc when low
- d_valid  out  1  head entry valid
- d_pc  out  ADDR_WIDTH  head pc
- d_instr  out  INSTR_WIDTH  head instruction
- d_tlb_fault  out  1  head entry carries an iTLB miss fault
- d_ready  in  1  decode consumes head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer; rd_ptr/wr_ptr each $clog2(DEPTH) bits, wrap modulo DEPTH; count tracked separately.
- Reset (highest priority): count=0, rd_ptr=wr_ptr=0, fault_block=0. Consequently d_valid=0, d_pc=0, d_instr=0, d_tlb_fault=0, f_ready=1.
- push = f_valid & f_cache_hit & f_ready & ~flush.
- Pushed entry = {f_pc, f_instr, fault}, with fault = f_tlb_enable & ~f_tlb_hit.
- f_valid with f_cache_hit=0 is a bubble: nothing written.
- pop = d_valid & d_ready & ~flush.
- f_ready = (count < DEPTH) & ~fault_block.
  - Purely combinational from registered state; does not depend on d_ready, so there is no pop-through when full.
- d_valid = (count != 0).
- d_pc, d_instr, d_tlb_fault = head entry when d_valid, else all zero.
- Latency without bypass: entry pushed in cycle N is visible on d_* in cycle N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Legal at any count except full, where push is blocked.
- Fault handling:
  - Pushing an entry with fault=1 sets fault_block=1 in the same edge.
  - Further pushes are refused until flush or reset.
  - Entries already queued still drain normally; the fault entry reaches decode and raises the exception there.
- Flush (sync, below reset):
  - Next cycle count=0, rd_ptr=wr_ptr=0, fault_block=0.
  - A push or pop coincident with flush is discarded; no entry survives.
  - Decode must ignore d_* in the flush cycle.
- Empty: d_valid=0; d_ready ignored; no pointer movement.
- Full: f_ready=0; f_valid ignored.
- count never exceeds DEPTH and never underflows. The bench asserts both.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN
- Defined:
  - When count==0, ~flush, and the push conditions hold, the incoming entry drives d_* combinationally with d_valid=1.
  - If d_ready is also high in that cycle, the entry is consumed and not written; count stays 0 and pointers do not move.
  - If d_ready is low, the entry is written as normal.
  - A bypassed fault entry still sets fault_block.
- Undefined: no combinational path from the f_* inputs to the d_* outputs; minimum latency is 1 cycle.

Test Plan:
- Reset, then push pc 0x100..0x10C (4 hits) with d_ready=0 -> count=4, f_ready=0. Then d_ready=1 for 4 cycles -> d_pc 0x100, 0x104, 0x108, 0x10C in order; count=0 after.
- Alternate f_cache_hit 1/0 on pcs 0x200, 0x204 (miss), 0x204 (hit), d_ready=1 -> decode sees exactly 0x200, 0x204; no duplicate, no bubble entry.
- count=2, push and pop same cycle -> count stays 2; d_pc advances to the second entry. Run 10 cycles steady-state to exercise pointer wrap.
- f_tlb_enable=1, f_tlb_hit=0 at pc 0x300 -> entry queued with d_tlb_fault=1 and f_ready=0 thereafter. Flush -> next cycle count=0, f_ready=1, d_valid=0.
- count=3 with flush, f_valid=1, f_cache_hit=1, d_ready=1 all in the same cycle -> next cycle count=0, d_valid=0. Reset asserted mid-drain -> all outputs at reset values next cycle.
- With FETCH_QUEUE_BYPASS_EN, queue empty, push 0x400 with d_ready=1 -> d_valid=1 and d_pc=0x400 in the same cycle; count remains 0.
